// File: rtl/vending_controller.sv
// Multi-product vending controller.
// Collects coins into a saturating credit register, tracks per-product stock,
// vends against a runtime price table and pays change/refunds coin-by-coin
// to the hopper over a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   coin_valid_i/val_i  coin presented (00=1, 01=2, 10=5, 11=10 rupees)
//   coin_accept_o       pulse: coin added to credit
//   coin_reject_o       pulse: coin bounced
//   sel_valid_i/id_i    product selection strobe and index
//   price_i             flattened price table, product i at [i*CW +: CW]
//   cancel_i            refund request
//   restock_i           reload every stock counter to STOCK_INIT
//   vend_o/vend_id_o    one-cycle dispense pulse and product index
//   sold_out_o          pulse: selected product has no stock
//   insufficient_o      pulse: credit below price
//   chg_valid_o/val_o   change coin request to hopper
//   chg_ready_i         hopper has taken the coin
//   credit_o            current credit
//   busy_o              high while not accepting coins/selections
module vending_controller #(
    parameter int unsigned N_PROD     = 4,
    parameter int unsigned CW         = 8,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 8,
    localparam int unsigned SEL_W     = (N_PROD > 1) ? $clog2(N_PROD) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid_i,
    input  logic [1:0]           coin_val_i,
    output logic                 coin_accept_o,
    output logic                 coin_reject_o,
    input  logic                 sel_valid_i,
    input  logic [SEL_W-1:0]     sel_id_i,
    input  logic [N_PROD*CW-1:0] price_i,
    input  logic                 cancel_i,
    input  logic                 restock_i,
    output logic                 vend_o,
    output logic [SEL_W-1:0]     vend_id_o,
    output logic                 sold_out_o,
    output logic                 insufficient_o,
    output logic                 chg_valid_o,
    output logic [1:0]           chg_val_o,
    input  logic                 chg_ready_i,
    output logic [CW-1:0]        credit_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        S_ACCEPT = 2'd0,
        S_VEND   = 2'd1,
        S_CHANGE = 2'd2
    } state_e;

    // Rupee value of a coin code.
    function automatic logic [3:0] coin_amt(input logic [1:0] code);
        case (code)
            2'b00:   coin_amt = 4'd1;
            2'b01:   coin_amt = 4'd2;
            2'b10:   coin_amt = 4'd5;
            default: coin_amt = 4'd10;
        endcase
    endfunction

    // Largest coin code whose value does not exceed c.
    function automatic logic [1:0] denom_code(input logic [CW-1:0] c);
        if (c >= CW'(10))     denom_code = 2'b11;
        else if (c >= CW'(5)) denom_code = 2'b10;
        else if (c >= CW'(2)) denom_code = 2'b01;
        else                  denom_code = 2'b00;
    endfunction

    state_e             state_q, state_d;
    logic [CW-1:0]      credit_q, credit_d;
    logic [STOCK_W-1:0] stock_q [N_PROD];

    logic               coin_accept_q, coin_accept_d;
    logic               coin_reject_q, coin_reject_d;
    logic               vend_q, vend_d;
    logic [SEL_W-1:0]   vend_id_q, vend_id_d;
    logic               sold_out_q, sold_out_d;
    logic               insufficient_q, insufficient_d;
    logic               chg_valid_q, chg_valid_d;
    logic [1:0]         chg_val_q, chg_val_d;
    logic               busy_q, busy_d;

    logic               sel_ok_c;
    logic [CW-1:0]      price_sel_c;
    logic [STOCK_W-1:0] stock_sel_c;
    logic [CW:0]        coin_sum_c;
    logic [CW-1:0]      chg_amt_c;
    logic               coin_acc_c, coin_rej_c, sold_c, insuf_c, buy_c, pay_c;

    // Selected product's price and stock; out-of-range ids select nothing.
    always_comb begin
        sel_ok_c    = (32'(sel_id_i) < N_PROD);
        price_sel_c = '0;
        stock_sel_c = '0;
        for (int unsigned i = 0; i < N_PROD; i++) begin
            if (sel_id_i == SEL_W'(i)) begin
                price_sel_c = price_i[i*CW +: CW];
                stock_sel_c = stock_q[i];
            end
        end
    end

    // One extra bit exposes credit overflow for the rejection rule.
    assign coin_sum_c = {1'b0, credit_q} + (CW+1)'(coin_amt(coin_val_i));
    assign chg_amt_c  = CW'(coin_amt(chg_val_q));

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_ACCEPT;
        else       state_q <= state_d;
    end

    // Next-state and event decode; ACCEPT priority is cancel > select > coin.
    always_comb begin
        state_d    = state_q;
        coin_acc_c = 1'b0;
        coin_rej_c = 1'b0;
        sold_c     = 1'b0;
        insuf_c    = 1'b0;
        buy_c      = 1'b0;
        pay_c      = 1'b0;
        case (state_q)
            S_ACCEPT: begin
                if (cancel_i) begin
                    coin_rej_c = coin_valid_i;
                    if (credit_q != '0) state_d = S_CHANGE;
                end else if (sel_valid_i && sel_ok_c) begin
                    coin_rej_c = coin_valid_i;
                    if (stock_sel_c == '0) begin
                        sold_c = 1'b1;
                    end else if (credit_q < price_sel_c) begin
                        insuf_c = 1'b1;
                    end else begin
                        buy_c   = 1'b1;
                        state_d = S_VEND;
                    end
                end else if (coin_valid_i) begin
                    coin_rej_c = coin_sum_c[CW];
                    coin_acc_c = !coin_sum_c[CW];
                end
            end
            S_VEND: begin
                coin_rej_c = coin_valid_i;
                state_d    = (credit_q != '0) ? S_CHANGE : S_ACCEPT;
            end
            S_CHANGE: begin
                coin_rej_c = coin_valid_i;
                if (chg_valid_q && chg_ready_i) begin
                    pay_c = 1'b1;
                    if (credit_q == chg_amt_c) state_d = S_ACCEPT;
                end
            end
            default: state_d = S_ACCEPT;
        endcase
    end

    // Output and datapath next values; change coin follows the next credit.
    always_comb begin
        credit_d = credit_q;
        if (coin_acc_c)  credit_d = coin_sum_c[CW-1:0];
        else if (buy_c)  credit_d = credit_q - price_sel_c;
        else if (pay_c)  credit_d = credit_q - chg_amt_c;
        coin_accept_d  = coin_acc_c;
        coin_reject_d  = coin_rej_c;
        vend_d         = buy_c;
        vend_id_d      = buy_c ? sel_id_i : '0;
        sold_out_d     = sold_c;
        insufficient_d = insuf_c;
        chg_valid_d    = (state_d == S_CHANGE);
        chg_val_d      = chg_valid_d ? denom_code(credit_d) : 2'b00;
        busy_d         = (state_d != S_ACCEPT);
    end

    // Credit and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            credit_q       <= '0;
            coin_accept_q  <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_q         <= 1'b0;
            vend_id_q      <= '0;
            sold_out_q     <= 1'b0;
            insufficient_q <= 1'b0;
            chg_valid_q    <= 1'b0;
            chg_val_q      <= 2'b00;
            busy_q         <= 1'b0;
        end else begin
            credit_q       <= credit_d;
            coin_accept_q  <= coin_accept_d;
            coin_reject_q  <= coin_reject_d;
            vend_q         <= vend_d;
            vend_id_q      <= vend_id_d;
            sold_out_q     <= sold_out_d;
            insufficient_q <= insufficient_d;
            chg_valid_q    <= chg_valid_d;
            chg_val_q      <= chg_val_d;
            busy_q         <= busy_d;
        end
    end

    // Stock counters; restock overrides a same-cycle sale.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_PROD; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int unsigned i = 0; i < N_PROD; i++) begin
                if (restock_i)
                    stock_q[i] <= STOCK_W'(STOCK_INIT);
                else if (buy_c && sel_id_i == SEL_W'(i))
                    stock_q[i] <= stock_q[i] - STOCK_W'(1);
            end
        end
    end

    assign coin_accept_o  = coin_accept_q;
    assign coin_reject_o  = coin_reject_q;
    assign vend_o         = vend_q;
    assign vend_id_o      = vend_id_q;
    assign sold_out_o     = sold_out_q;
    assign insufficient_o = insufficient_q;
    assign chg_valid_o    = chg_valid_q;
    assign chg_val_o      = chg_val_q;
    assign credit_o       = credit_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_vending_controller.sv
// Directed testbench for vending_controller (STOCK_INIT=1 so sell-out is quick).
module tb_vending_controller;

    localparam int unsigned N_PROD     = 4;
    localparam int unsigned CW         = 8;
    localparam int unsigned STOCK_W    = 4;
    localparam int unsigned STOCK_INIT = 1;
    localparam int unsigned SEL_W      = 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 coin_valid = 1'b0;
    logic [1:0]           coin_val = 2'b00;
    logic                 coin_accept, coin_reject;
    logic                 sel_valid = 1'b0;
    logic [SEL_W-1:0]     sel_id = '0;
    logic [N_PROD*CW-1:0] price = '0;
    logic                 cancel = 1'b0;
    logic                 restock = 1'b0;
    logic                 vend;
    logic [SEL_W-1:0]     vend_id;
    logic                 sold_out, insufficient;
    logic                 chg_valid;
    logic [1:0]           chg_val;
    logic                 chg_ready = 1'b0;
    logic [CW-1:0]        credit;
    logic                 busy;

    int total = 0;
    int bad   = 0;

    vending_controller #(
        .N_PROD(N_PROD), .CW(CW), .STOCK_W(STOCK_W), .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk(clk), .reset(reset),
        .coin_valid_i(coin_valid), .coin_val_i(coin_val),
        .coin_accept_o(coin_accept), .coin_reject_o(coin_reject),
        .sel_valid_i(sel_valid), .sel_id_i(sel_id), .price_i(price),
        .cancel_i(cancel), .restock_i(restock),
        .vend_o(vend), .vend_id_o(vend_id),
        .sold_out_o(sold_out), .insufficient_o(insufficient),
        .chg_valid_o(chg_valid), .chg_val_o(chg_val), .chg_ready_i(chg_ready),
        .credit_o(credit), .busy_o(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] v);
        coin_valid = 1'b1; coin_val = v;
        tick();
        coin_valid = 1'b0;
    endtask

    task automatic select(input logic [SEL_W-1:0] id);
        sel_valid = 1'b1; sel_id = id;
        tick();
        sel_valid = 1'b0;
    endtask

    task automatic do_restock();
        restock = 1'b1;
        tick();
        restock = 1'b0;
    endtask

    task automatic test_reset();
        tick(); tick();
        total++; if ({coin_accept, coin_reject, vend, vend_id, sold_out, insufficient, chg_valid, chg_val, busy} !== '0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0", {coin_accept, coin_reject, vend, vend_id, sold_out, insufficient, chg_valid, chg_val, busy}); end
        total++; if (credit !== 8'd0) begin bad++; $display("FAIL reset_credit got=%0d want=0", credit); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_exact_vend();
        price[0*CW +: CW] = 8'd12;
        coin(2'b11);
        total++; if ({coin_accept, credit} !== {1'b1, 8'd10}) begin bad++; $display("FAIL exact_coin10 acc=%b credit=%0d want acc=1 credit=10", coin_accept, credit); end
        coin(2'b01);
        total++; if ({coin_accept, credit} !== {1'b1, 8'd12}) begin bad++; $display("FAIL exact_coin2 acc=%b credit=%0d want acc=1 credit=12", coin_accept, credit); end
        select(2'd0);
        total++; if ({vend, vend_id, credit, busy} !== {1'b1, 2'd0, 8'd0, 1'b1}) begin
            bad++; $display("FAIL exact_vend vend=%b id=%0d credit=%0d busy=%b want 1/0/0/1", vend, vend_id, credit, busy); end
        tick();
        total++; if ({vend, chg_valid, busy, credit} !== {1'b0, 1'b0, 1'b0, 8'd0}) begin
            bad++; $display("FAIL exact_after vend=%b chg_valid=%b busy=%b credit=%0d want 0/0/0/0", vend, chg_valid, busy, credit); end
    endtask

    task automatic test_change();
        price[1*CW +: CW] = 8'd13;
        chg_ready = 1'b1;
        coin(2'b11); coin(2'b11);
        total++; if (credit !== 8'd20) begin bad++; $display("FAIL change_credit20 got=%0d want=20", credit); end
        select(2'd1);
        total++; if ({vend, vend_id, credit, chg_valid} !== {1'b1, 2'd1, 8'd7, 1'b0}) begin
            bad++; $display("FAIL change_vend vend=%b id=%0d credit=%0d chg_valid=%b want 1/1/7/0", vend, vend_id, credit, chg_valid); end
        tick();
        total++; if ({chg_valid, chg_val, credit} !== {1'b1, 2'b10, 8'd7}) begin
            bad++; $display("FAIL change_coin5 valid=%b val=%b credit=%0d want 1/10/7", chg_valid, chg_val, credit); end
        tick();
        total++; if ({chg_valid, chg_val, credit} !== {1'b1, 2'b01, 8'd2}) begin
            bad++; $display("FAIL change_coin2 valid=%b val=%b credit=%0d want 1/01/2", chg_valid, chg_val, credit); end
        tick();
        total++; if ({chg_valid, credit, busy} !== {1'b0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL change_done valid=%b credit=%0d busy=%b want 0/0/0", chg_valid, credit, busy); end
        chg_ready = 1'b0;
    endtask

    task automatic test_stall();
        do_restock();
        coin(2'b11); coin(2'b11);
        select(2'd1);
        total++; if ({vend, credit} !== {1'b1, 8'd7}) begin bad++; $display("FAIL stall_vend vend=%b credit=%0d want 1/7", vend, credit); end
        tick();
        for (int i = 0; i < 5; i++) begin
            total++; if ({chg_valid, chg_val, credit} !== {1'b1, 2'b10, 8'd7}) begin
                bad++; $display("FAIL stall_hold%0d valid=%b val=%b credit=%0d want 1/10/7", i, chg_valid, chg_val, credit); end
            tick();
        end
        chg_ready = 1'b1;
        tick();
        total++; if ({chg_valid, chg_val, credit} !== {1'b1, 2'b01, 8'd2}) begin
            bad++; $display("FAIL stall_release valid=%b val=%b credit=%0d want 1/01/2", chg_valid, chg_val, credit); end
        tick();
        total++; if ({chg_valid, credit} !== {1'b0, 8'd0}) begin bad++; $display("FAIL stall_done valid=%b credit=%0d want 0/0", chg_valid, credit); end
        chg_ready = 1'b0;
    endtask

    task automatic test_cancel();
        coin(2'b10); coin(2'b01); coin(2'b00);
        total++; if (credit !== 8'd8) begin bad++; $display("FAIL cancel_credit8 got=%0d want=8", credit); end
        chg_ready = 1'b1;
        cancel = 1'b1; coin_valid = 1'b1; coin_val = 2'b01;
        tick();
        cancel = 1'b0; coin_valid = 1'b0;
        total++; if ({coin_reject, coin_accept, credit, chg_valid, chg_val} !== {1'b1, 1'b0, 8'd8, 1'b1, 2'b10}) begin
            bad++; $display("FAIL cancel_start rej=%b acc=%b credit=%0d valid=%b val=%b want 1/0/8/1/10", coin_reject, coin_accept, credit, chg_valid, chg_val); end
        tick();
        total++; if ({chg_val, credit} !== {2'b01, 8'd3}) begin bad++; $display("FAIL cancel_coin2 val=%b credit=%0d want 01/3", chg_val, credit); end
        tick();
        total++; if ({chg_valid, chg_val, credit} !== {1'b1, 2'b00, 8'd1}) begin bad++; $display("FAIL cancel_coin1 valid=%b val=%b credit=%0d want 1/00/1", chg_valid, chg_val, credit); end
        tick();
        total++; if ({chg_valid, credit, busy} !== {1'b0, 8'd0, 1'b0}) begin bad++; $display("FAIL cancel_done valid=%b credit=%0d busy=%b want 0/0/0", chg_valid, credit, busy); end
        chg_ready = 1'b0;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        total++; if ({busy, chg_valid, coin_reject} !== 3'b000) begin bad++; $display("FAIL cancel_zero busy=%b valid=%b rej=%b want 000", busy, chg_valid, coin_reject); end
    endtask

    task automatic test_sold_out();
        do_restock();
        price[2*CW +: CW] = 8'd5;
        coin(2'b10);
        select(2'd2);
        total++; if ({vend, vend_id, credit} !== {1'b1, 2'd2, 8'd0}) begin bad++; $display("FAIL sold_first vend=%b id=%0d credit=%0d want 1/2/0", vend, vend_id, credit); end
        tick();
        coin(2'b10);
        select(2'd2);
        total++; if ({sold_out, vend, insufficient, credit, busy} !== {1'b1, 1'b0, 1'b0, 8'd5, 1'b0}) begin
            bad++; $display("FAIL sold_second sold=%b vend=%b insuf=%b credit=%0d busy=%b want 1/0/0/5/0", sold_out, vend, insufficient, credit, busy); end
        do_restock();
        select(2'd2);
        total++; if ({vend, vend_id, credit, sold_out} !== {1'b1, 2'd2, 8'd0, 1'b0}) begin
            bad++; $display("FAIL sold_restock vend=%b id=%0d credit=%0d sold=%b want 1/2/0/0", vend, vend_id, credit, sold_out); end
        tick();
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 25; i++) coin(2'b11);
        total++; if (credit !== 8'd250) begin bad++; $display("FAIL ovf_credit250 got=%0d want=250", credit); end
        coin(2'b11);
        total++; if ({coin_reject, coin_accept, credit} !== {1'b1, 1'b0, 8'd250}) begin
            bad++; $display("FAIL ovf_reject10 rej=%b acc=%b credit=%0d want 1/0/250", coin_reject, coin_accept, credit); end
        coin(2'b10);
        total++; if ({coin_accept, credit} !== {1'b1, 8'd255}) begin bad++; $display("FAIL ovf_fill255 acc=%b credit=%0d want 1/255", coin_accept, credit); end
        coin(2'b00);
        total++; if ({coin_reject, credit} !== {1'b1, 8'd255}) begin bad++; $display("FAIL ovf_reject1 rej=%b credit=%0d want 1/255", coin_reject, credit); end
        chg_ready = 1'b1;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        for (int i = 0; i < 64 && busy; i++) tick();
        total++; if ({busy, credit} !== {1'b0, 8'd0}) begin bad++; $display("FAIL ovf_drain busy=%b credit=%0d want 0/0", busy, credit); end
        chg_ready = 1'b0;
    endtask

    task automatic test_insufficient_and_reset();
        price[0*CW +: CW] = 8'd12;
        coin(2'b10);
        select(2'd0);
        total++; if ({insufficient, vend, sold_out, credit} !== {1'b1, 1'b0, 1'b0, 8'd5}) begin
            bad++; $display("FAIL insuf insuf=%b vend=%b sold=%b credit=%0d want 1/0/0/5", insufficient, vend, sold_out, credit); end
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        total++; if ({chg_valid, chg_val, credit} !== {1'b1, 2'b10, 8'd5}) begin
            bad++; $display("FAIL rstchg_pre valid=%b val=%b credit=%0d want 1/10/5", chg_valid, chg_val, credit); end
        #2;
        reset = 1'b1;
        #1;
        total++; if ({chg_valid, credit, busy} !== {1'b0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL rstchg_async valid=%b credit=%0d busy=%b want 0/0/0", chg_valid, credit, busy); end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        coin(2'b11); coin(2'b01);
        sel_valid = 1'b1; sel_id = 2'd0; coin_valid = 1'b1; coin_val = 2'b00;
        tick();
        sel_valid = 1'b0;
        total++; if ({vend, coin_reject, coin_accept, credit} !== {1'b1, 1'b1, 1'b0, 8'd0}) begin
            bad++; $display("FAIL b2b_sel_coin vend=%b rej=%b acc=%b credit=%0d want 1/1/0/0", vend, coin_reject, coin_accept, credit); end
        tick();
        coin_valid = 1'b0;
        total++; if ({coin_reject, coin_accept, credit, busy} !== {1'b1, 1'b0, 8'd0, 1'b0}) begin
            bad++; $display("FAIL b2b_vend_coin rej=%b acc=%b credit=%0d busy=%b want 1/0/0/0", coin_reject, coin_accept, credit, busy); end
    endtask

    initial begin
        test_reset();
        test_exact_vend();
        test_change();
        test_stall();
        test_cancel();
        test_sold_out();
        test_overflow();
        test_insufficient_and_reset();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
